// File: rtl/taylor_exp_engine.sv
// taylor_exp_engine: computes e^x for an unsigned Q0.8 operand by accumulating
// Taylor terms. Each term is derived from the previous one as
// term * x * coef[k], with coef read from an external combinational ROM
// holding 1/(k+1) in Q0.8. The result is unsigned Q8.8.
module taylor_exp_engine #(
  parameter int TERMS = 8  // Taylor terms after the constant 1.0, legal 1..12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  x,
  output logic [3:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [2:0] {
    IDLE,
    MUL_X,
    MUL_C,
    ACC,
    DONE
  } state_t;

  localparam logic [3:0]  K_LAST = 4'(TERMS - 1);
  localparam logic [15:0] ONE_Q88 = 16'h0100;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  x_reg;
  logic [15:0] term;
  logic [15:0] sum;
  logic [3:0]  k;
  logic [23:0] prod_x;
  logic [31:0] prod_c;
  logic [16:0] sum_ext;
  logic [15:0] sum_sat;

  // Q8.8 * Q0.8 and Q8.8 * Q0.8 (ROM) products; the >>8 keeps Q8.8 and the
  // bit slice truncates to 16 bits with no rounding.
  assign prod_x  = 24'(term) * 24'(x_reg);
  assign prod_c  = 32'(term) * 32'(rom_data);
  assign sum_ext = 17'(sum) + 17'(term);
  assign sum_sat = sum_ext[16] ? 16'hFFFF : sum_ext[15:0];

  // The ROM is addressed straight from the iteration counter.
  assign rom_addr = k;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so requests during a
  // run or in DONE are dropped rather than queued.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_nxt
    // unassigned, which would infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL_X;
      MUL_X:   state_nxt = MUL_C;
      MUL_C:   state_nxt = ACC;
      ACC:     state_nxt = (k == K_LAST) ? DONE : MUL_X;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: busy covers the three iteration states only.
  always_comb begin
    busy = 1'b0;
    case (state)
      MUL_X, MUL_C, ACC: busy = 1'b1;
      default:           busy = 1'b0;
    endcase
  end

  // Datapath: operand capture, term recurrence, saturating accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      term  <= '0;
      sum   <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x_reg <= x;
            term  <= ONE_Q88;
            sum   <= ONE_Q88;
            k     <= '0;
          end
        end
        MUL_X: term <= prod_x[23:8];
        MUL_C: term <= prod_c[23:8];
        ACC: begin
          sum <= sum_sat;
          if (k != K_LAST) k <= k + 4'd1;
        end
        DONE:    k <= '0;
        default: ;
      endcase
    end
  end

  // Result publication: result and the done pulse both appear on the edge
  // that leaves DONE, so result is already valid while done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) result <= sum;
    end
  end

endmodule

// File: tb/tb_taylor_exp_engine.sv
// Bench for taylor_exp_engine: a ROM model feeds each instance, and results
// are compared against a plain-arithmetic Taylor model of e^x.
module tb_taylor_exp_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  x = '0;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        busy;
  logic        done;
  logic [15:0] result;

  logic        start1 = 1'b0;
  logic [7:0]  x1 = '0;
  logic [3:0]  rom_addr1;
  logic [15:0] rom_data1;
  logic        busy1;
  logic        done1;
  logic [15:0] result1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  taylor_exp_engine #(.TERMS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .done(done), .result(result)
  );

  taylor_exp_engine #(.TERMS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .busy(busy1), .done(done1), .result(result1)
  );

  // Coefficient ROM: 1/(k+1) in Q0.8, entry 0 stored as 255.
  function automatic logic [15:0] rom_val(input logic [3:0] a);
    int v;
    v = (a == 4'd0) ? 255 : 256 / (int'(a) + 1);
    return 16'(v);
  endfunction

  always_comb rom_data  = rom_val(rom_addr);
  always_comb rom_data1 = rom_val(rom_addr1);

  // Reference: e^x as 1 + sum of truncated Taylor terms, Q8.8 saturating.
  function automatic logic [15:0] exp_model(input int xv, input int terms);
    int t;
    int s;
    t = 256;
    s = 256;
    for (int i = 0; i < terms; i++) begin
      t = ((t * xv) >> 8) & 32'hFFFF;
      t = ((t * int'(rom_val(4'(i)))) >> 8) & 32'hFFFF;
      s = s + t;
      if (s > 65535) s = 65535;
    end
    return 16'(s);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for its done pulse.
  task automatic launch(input logic [7:0] xv, output int lat,
                        output logic [15:0] res, output int busy_cnt);
    x = xv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    res = '0;
    busy_cnt = busy ? 1 : 0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (done) begin
        lat = c;
        res = result;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({busy, done, result, rom_addr} !== 22'h0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b result=%h rom_addr=%h, want all zero",
               busy, done, result, rom_addr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_x_zero();
    int lat;
    int bc;
    logic [15:0] res;
    launch(8'h00, lat, res, bc);
    vectors++;
    if (res !== 16'h0100) begin
      miscompares++;
      $display("FAIL x_zero_result: got %h want 0100", res);
    end
    vectors++;
    if (lat !== 25) begin
      miscompares++;
      $display("FAIL x_zero_latency: got %0d want 25", lat);
    end
    vectors++;
    if (bc !== 24) begin
      miscompares++;
      $display("FAIL x_zero_busy_cycles: got %0d want 24", bc);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || result !== 16'h0100) begin
      miscompares++;
      $display("FAIL done_one_cycle: done=%b result=%h want 0 / 0100", done, result);
    end
  endtask

  task automatic test_known();
    logic [7:0] xs [2];
    int lat;
    int bc;
    logic [15:0] res;
    logic [15:0] exp_res;
    xs[0] = 8'h80;
    xs[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      exp_res = exp_model(int'(xs[i]), 8);
      launch(xs[i], lat, res, bc);
      vectors++;
      if (res !== exp_res || lat !== 25) begin
        miscompares++;
        $display("FAIL known_x%h: result=%h lat=%0d want %h lat=25",
                 xs[i], res, lat, exp_res);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [7:0] xv;
    int lat;
    int bc;
    logic [15:0] res;
    logic [15:0] exp_res;
    for (int i = 0; i < 12; i++) begin
      xv = 8'($urandom_range(0, 255));
      exp_res = exp_model(int'(xv), 8);
      launch(xv, lat, res, bc);
      vectors++;
      if (res !== exp_res || lat !== 25 || bc !== 24) begin
        miscompares++;
        $display("FAIL random_x%h: result=%h lat=%0d busy=%0d want %h 25 24",
                 xv, res, lat, bc, exp_res);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_protocol();
    int dones;
    int busy_after;
    dones = 0;
    busy_after = 0;
    x = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 24; n++) begin
      vectors++;
      if (rom_addr !== 4'(n / 3)) begin
        miscompares++;
        $display("FAIL rom_addr_step_c%0d: got %0d want %0d", n, rom_addr, n / 3);
      end
      if (n == 4) begin
        start = 1'b1;
        x = 8'h10;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) dones++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    if (done) dones++;
    vectors++;
    if (result !== 16'h01A2) begin
      miscompares++;
      $display("FAIL protocol_result: got %h want 01a2", result);
    end
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done) dones++;
      if (busy) busy_after++;
    end
    vectors++;
    if (dones !== 1 || busy_after !== 0) begin
      miscompares++;
      $display("FAIL protocol_ignored_start: dones=%0d busy_after=%0d want 1 / 0",
               dones, busy_after);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int bc;
    int stray;
    logic [15:0] res;
    stray = 0;
    x = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    rst_n = 1'b0;
    x = 8'h80;
    #1;
    vectors++;
    if (busy !== 1'b0 || result !== 16'h0000 || rom_addr !== 4'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_abort: busy=%b result=%h rom_addr=%h done=%b want 0",
               busy, result, rom_addr, done);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (done || busy) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_resume: active cycles=%0d want 0", stray);
    end
    launch(8'h80, lat, res, bc);
    vectors++;
    if (res !== 16'h01A2 || lat !== 25) begin
      miscompares++;
      $display("FAIL reset_mid_restart: result=%h lat=%0d want 01a2 25", res, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] xa;
    logic [7:0] xb;
    int first_c;
    int second_c;
    logic [15:0] first_r;
    logic [15:0] second_r;
    xa = 8'($urandom_range(0, 255));
    xb = 8'($urandom_range(0, 255));
    first_c = -1;
    second_c = -1;
    first_r = '0;
    second_r = '0;
    x = xa;
    start = 1'b1;
    tick();
    x = xb;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (done) begin
        if (first_c < 0) begin
          first_c = c;
          first_r = result;
        end else begin
          second_c = c;
          second_r = result;
          break;
        end
      end
    end
    start = 1'b0;
    vectors++;
    if (first_c !== 25 || first_r !== exp_model(int'(xa), 8)) begin
      miscompares++;
      $display("FAIL b2b_first: at %0d result=%h want 25 %h",
               first_c, first_r, exp_model(int'(xa), 8));
    end
    vectors++;
    if (second_c !== 51 || second_r !== exp_model(int'(xb), 8)) begin
      miscompares++;
      $display("FAIL b2b_second: at %0d result=%h want 51 %h",
               second_c, second_r, exp_model(int'(xb), 8));
    end
    tick();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_release: busy=%b want 0", busy);
    end
  endtask

  task automatic test_terms1();
    int lat;
    logic [15:0] res;
    lat = -1;
    res = '0;
    x1 = 8'hFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (done1) begin
        lat = c;
        res = result1;
        break;
      end
    end
    vectors++;
    if (res !== exp_model(255, 1) || lat !== 4) begin
      miscompares++;
      $display("FAIL terms1: result=%h lat=%0d want %h 4", res, lat, exp_model(255, 1));
    end
  endtask

  initial begin
    test_reset();
    test_x_zero();
    test_known();
    test_random();
    test_protocol();
    test_reset_mid();
    test_back_to_back();
    test_terms1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
